// File: rtl/seq_mult_mmio.sv
// seq_mult_mmio
// Memory-mapped 32x32 -> 64-bit unsigned sequential multiplier. The CPU
// loads OP_A and OP_B and then writes CTRL.bit0=1. One shift-add step runs
// per clock for 32 clocks. The product then appears in RES_HI:RES_LO,
// STATUS.done is set, and irq pulses for one cycle.
//
// Register window (word offsets from BASE_ADDR):
//   0 OP_A (RW)   1 OP_B (RW)   2 CTRL (W, bit0 start, reads 0)
//   3 STATUS (R, bit0 busy, bit1 done)   4 RES_LO (R)   5 RES_HI (R)
//
// Ports:
//   clk        single clock, rising edge
//   resetn     asynchronous active-low reset
//   mem_valid  bus request valid
//   mem_addr   byte address
//   mem_wdata  write data
//   mem_wstrb  byte strobes, 0 = read
//   mem_ready  one-cycle acknowledge for a window hit
//   mem_rdata  read data, valid while mem_ready is high
//   irq        one-cycle completion pulse
module seq_mult_mmio #(
    parameter logic [31:0] BASE_ADDR = 32'h1000_0100
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        mem_valid,
    input  logic [31:0] mem_addr,
    input  logic [31:0] mem_wdata,
    input  logic [3:0]  mem_wstrb,
    output logic        mem_ready,
    output logic [31:0] mem_rdata,
    output logic        irq
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] opA_q, opA_d;
    logic [31:0] opB_q, opB_d;
    logic [31:0] mcand_q, mcand_d;
    logic [31:0] mplier_q, mplier_d;
    logic [63:0] acc_q, acc_d;
    logic [4:0]  count_q, count_d;
    logic [31:0] resLo_q, resLo_d;
    logic [31:0] resHi_q, resHi_d;
    logic        done_q, done_d;
    logic        ready_q, ready_d;
    logic        irq_q, irq_d;
    logic [31:0] rdata_q, rdata_d;

    logic        hit;
    logic        accept;
    logic        isWrite;
    logic        busy;
    logic        startReq;
    logic [2:0]  wordSel;
    logic [63:0] addend;
    logic [63:0] accSum;
    logic        unusedAddrBits;

    // Replace only the bytes whose strobe is set.
    function automatic logic [31:0] mergeBytes(input logic [31:0] oldVal,
                                               input logic [31:0] newVal,
                                               input logic [3:0]  strb);
        logic [31:0] merged;
        merged = oldVal;
        for (int b = 0; b < 4; b++) begin
            if (strb[b]) begin
                merged[b*8 +: 8] = newVal[b*8 +: 8];
            end
        end
        return merged;
    endfunction

    assign wordSel        = mem_addr[4:2];
    assign hit            = mem_valid && (mem_addr[31:5] == BASE_ADDR[31:5]) && (wordSel <= 3'd5);
    // A request is taken only when no ack is showing. The cycle after an ack
    // is therefore always dead, and a request held across its ack edge is not
    // acknowledged twice.
    assign accept         = hit && !ready_q;
    assign isWrite        = |mem_wstrb;
    assign busy           = (state_q == RUN);
    assign startReq       = accept && isWrite && (wordSel == 3'd2) && mem_wstrb[0] && mem_wdata[0];
    assign addend         = mplier_q[0] ? ({32'd0, mcand_q} << count_q) : 64'd0;
    assign accSum         = acc_q + addend;
    assign unusedAddrBits = ^mem_addr[1:0];

    // Bus decode, register writes and the IDLE/RUN/DONE sequencing. The
    // result registers are only loaded on the final step, so partial sums
    // never reach the bus.
    always_comb begin
        state_d  = state_q;
        opA_d    = opA_q;
        opB_d    = opB_q;
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        acc_d    = acc_q;
        count_d  = count_q;
        resLo_d  = resLo_q;
        resHi_d  = resHi_q;
        done_d   = done_q;
        ready_d  = accept;
        rdata_d  = 32'd0;
        irq_d    = 1'b0;

        if (accept && isWrite && !busy) begin
            case (wordSel)
                3'd0:    opA_d = mergeBytes(opA_q, mem_wdata, mem_wstrb);
                3'd1:    opB_d = mergeBytes(opB_q, mem_wdata, mem_wstrb);
                default: ;
            endcase
        end

        if (accept && !isWrite) begin
            case (wordSel)
                3'd0:    rdata_d = opA_q;
                3'd1:    rdata_d = opB_q;
                3'd3:    rdata_d = {30'd0, done_q, busy};
                3'd4:    rdata_d = resLo_q;
                3'd5:    rdata_d = resHi_q;
                default: rdata_d = 32'd0;
            endcase
        end

        case (state_q)
            IDLE, DONE: begin
                if (startReq) begin
                    mcand_d  = opA_q;
                    mplier_d = opB_q;
                    acc_d    = 64'd0;
                    count_d  = 5'd0;
                    done_d   = 1'b0;
                    state_d  = RUN;
                end
            end
            RUN: begin
                acc_d    = accSum;
                mplier_d = mplier_q >> 1;
                count_d  = count_q + 5'd1;
                if (count_q == 5'd31) begin
                    resLo_d = accSum[31:0];
                    resHi_d = accSum[63:32];
                    done_d  = 1'b1;
                    irq_d   = 1'b1;
                    state_d = DONE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State registers. Reset clears everything, which aborts a run in
    // progress without leaving done set or an irq pending.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q  <= IDLE;
            opA_q    <= 32'd0;
            opB_q    <= 32'd0;
            mcand_q  <= 32'd0;
            mplier_q <= 32'd0;
            acc_q    <= 64'd0;
            count_q  <= 5'd0;
            resLo_q  <= 32'd0;
            resHi_q  <= 32'd0;
            done_q   <= 1'b0;
            ready_q  <= 1'b0;
            irq_q    <= 1'b0;
            rdata_q  <= 32'd0;
        end else begin
            state_q  <= state_d;
            opA_q    <= opA_d;
            opB_q    <= opB_d;
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            acc_q    <= acc_d;
            count_q  <= count_d;
            resLo_q  <= resLo_d;
            resHi_q  <= resHi_d;
            done_q   <= done_d;
            ready_q  <= ready_d;
            irq_q    <= irq_d;
            rdata_q  <= rdata_d;
        end
    end

    assign mem_ready = ready_q;
    assign mem_rdata = rdata_q;
    assign irq       = irq_q;

endmodule

// File: doc/seq_mult_mmio.md
SEQ_MULT_MMIO -- requirements
Module: seq_mult_mmio

Interface
REQ-001 The block SHALL have parameter BASE_ADDR, default 32'h1000_0100, the word-aligned base of its 6-word register window.
REQ-002 The block SHALL have port clk  input  1  the single clock; all state SHALL change on its rising edge.
REQ-003 The block SHALL have port resetn  input  1  reset, asynchronous assert and active-low.
REQ-004 The block SHALL have port mem_valid  input  1  the CPU bus request-valid.
REQ-005 The block SHALL have port mem_addr  input  32  the CPU byte address.
REQ-006 The block SHALL have port mem_wdata  input  32  the CPU write data.
REQ-007 The block SHALL have port mem_wstrb  input  4  the byte strobes; 4'b0000 means read, nonzero means write.
REQ-008 The block SHALL have port mem_ready  output  1  a one-cycle acknowledge for a request that hits the window.
REQ-009 The block SHALL have port mem_rdata  output  32  the read data, valid while mem_ready=1.
REQ-010 The block SHALL have port irq  output  1  a one-cycle pulse on multiply completion.

Function
REQ-011 Hit SHALL mean mem_valid=1, mem_addr[31:5]==BASE_ADDR[31:5] and mem_addr[4:2] in 0..5; non-hits SHALL be ignored, with mem_ready held at 0.
REQ-012 Register map (word offset) SHALL be: 0 OP_A (RW), 1 OP_B (RW), 2 CTRL (W, bit0=start, reads 0), 3 STATUS (R, bit0=busy, bit1=done), 4 RES_LO (R), 5 RES_HI (R).
REQ-013 mem_ready SHALL assert exactly one cycle after a hit is first seen and SHALL stay 0 in the cycle after any acknowledge, giving one ack per request.
REQ-014 Register writes SHALL take effect on the ack edge and SHALL honour mem_wstrb per byte; writes to read-only offsets SHALL be ignored.
REQ-015 The FSM SHALL have states IDLE, RUN and DONE.
REQ-016 IDLE/DONE: an acked write to CTRL with wdata[0]=1 SHALL load the multiplicand and multiplier from OP_A/OP_B, clear the 64-bit accumulator, set count=0, clear done, and enter RUN.
REQ-017 RUN SHALL perform one unsigned shift-add step per cycle: if the multiplier LSB is 1, add the multiplicand shifted left by count into the accumulator; then shift the multiplier right and increment count.
REQ-018 After the 32nd RUN cycle, the FSM SHALL write RES_HI:RES_LO = accumulator, enter DONE, set done, and pulse irq for one cycle.
REQ-019 Latency SHALL be 32 cycles from the start ack edge to busy=0/done=1.
REQ-020 busy SHALL equal (state==RUN).
REQ-021 done SHALL be sticky until the next accepted start.
REQ-022 While busy, writes to OP_A, OP_B and CTRL SHALL be acked but ignored, and reads of RES_LO/RES_HI SHALL return the previous result.
REQ-023 RES_LO/RES_HI SHALL update only at completion and SHALL never expose partial sums.
REQ-024 A start with wdata[0]=0 SHALL be a no-op.
REQ-025 A start in DONE SHALL behave identically to a start in IDLE.
REQ-026 The product SHALL be a full unsigned 64-bit result, with no overflow or truncation (0xFFFFFFFF*0xFFFFFFFF = 0xFFFFFFFE_00000001).

Reset
REQ-027 On resetn=0, the block SHALL asynchronously force state=IDLE, OP_A, OP_B, RES_LO, RES_HI, count and accumulator to 0, and mem_ready, mem_rdata and irq to 0.
REQ-028 Reset asserted mid-RUN SHALL abort the operation without setting done or pulsing irq.
REQ-029 On deassertion, the block SHALL accept a request on the first clk edge.

Verification
REQ-030 The bench SHALL check: write OP_A=7, OP_B=6, CTRL=1, poll STATUS -> busy for 32 cycles, then STATUS=2'b10, RES_LO=42, RES_HI=0, and exactly one irq pulse.
REQ-031 The bench SHALL check: OP_A=OP_B=0xFFFFFFFF, start -> RES_HI=0xFFFFFFFE, RES_LO=0x00000001.
REQ-032 The bench SHALL check: start A=3, B=5, then write OP_A=9 and a second CTRL=1 at cycle 10 of RUN -> result=15, and OP_A still reads 3.
REQ-033 The bench SHALL check: a byte-strobed write of 0xAABBCCDD with wstrb=4'b0010 to a zeroed OP_B -> OP_B reads 0x0000CC00.
REQ-034 The bench SHALL check: resetn pulsed low at cycle 15 of RUN -> all registers read 0, STATUS=0, and no irq.
REQ-035 The bench SHALL check: an access to BASE_ADDR+0x18 and an access to an out-of-window address -> mem_ready stays 0; back-to-back hits -> exactly one ack per request.
